// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared types, defaults and helpers for the instruction fetch
//               unit and the instruction BRAM it drives.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

  // Instruction word and instruction byte-address buses
  typedef logic [31:0] InstBus;
  typedef logic [31:0] InstAddrBus;

  // Byte address fetched first after reset
  localparam InstAddrBus RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch state encoding
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } ifu_state_e;

  // Number of bits needed to hold 'value' (at least 1); the instruction BRAM
  // uses the same function for its address width
  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n = n + 1;
      v = v >> 1;
    end
    if (n == 0) begin
      n = 1;
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// Module      : ifu
// Description : Instruction fetch unit. Owns the fetch PC, drives the BRAM
//               A-port (one-cycle registered read), and presents
//               instruction/PC pairs to decode over a valid/ready handshake.
//               Redirects from execute kill the wrong-path slot and restart
//               fetch with no further bubble.
//               Optional feature macro: IFU_MISALIGN_EXC_EN - misaligned
//               redirects raise fetch_misalign and park the unit in TRAP.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu
  import ifu_pkg::*;
#(
  parameter InstAddrBus RESET_PC  = RESET_PC_DEFAULT,
  parameter int         RAM_DEPTH = 65536,
  localparam int        AW        = clogb2(RAM_DEPTH - 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          jump_en,
  input  InstAddrBus    jump_addr,
  input  logic          halt,
  output logic          iram_en,
  output logic [AW-1:0] iram_addr,
  input  InstBus        iram_rdata,
  output logic          if_valid,
  input  logic          id_ready,
  output InstBus        if_inst,
  output InstAddrBus    if_pc,
  output logic          fetch_misalign,
  output InstAddrBus    misalign_addr
);

  ifu_state_e state_q;
  InstAddrBus pc_req_q;   // next address to request
  InstAddrBus pc_rsp_q;   // address of the in-flight / presented word
  logic       rsp_vld_q;  // a word is presented on the BRAM output

  logic       jump_ok;    // redirect that actually fetches
  logic       jump_bad;   // redirect rejected as misaligned
  InstAddrBus jump_tgt;
  logic       stall;

`ifdef IFU_MISALIGN_EXC_EN
  assign jump_tgt = jump_addr;
  assign jump_ok  = jump_en & (jump_addr[1:0] == 2'b00);
  assign jump_bad = jump_en & (jump_addr[1:0] != 2'b00);
`else
  // Low address bits are simply dropped; every redirect is word aligned
  logic unused_jump_lsb;
  assign unused_jump_lsb = ^jump_addr[1:0];
  assign jump_tgt = {jump_addr[31:2], 2'b00};
  assign jump_ok  = jump_en;
  assign jump_bad = 1'b0;
`endif

  // Decode holding off a presented word; a redirect always breaks the stall
  assign stall = rsp_vld_q & ~id_ready & ~jump_en;

  // BRAM port-A request: redirect target first, else sequential fetch when free
  always_comb begin
    iram_en   = 1'b0;
    iram_addr = pc_req_q[AW+1:2];
    if (jump_ok) begin
      iram_en   = 1'b1;
      iram_addr = jump_tgt[AW+1:2];
    end else if (!jump_en && (state_q == ST_RUN) && !stall && !halt) begin
      iram_en = 1'b1;
    end
  end

  // Fetch state machine and PC bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_req_q  <= RESET_PC;
      pc_rsp_q  <= RESET_PC;
      rsp_vld_q <= 1'b0;
    end else if (jump_ok) begin
      state_q   <= ST_RUN;
      rsp_vld_q <= 1'b1;
      pc_rsp_q  <= jump_tgt;
      pc_req_q  <= jump_tgt + 32'd4;
    end else if (jump_bad) begin
      state_q   <= ST_TRAP;
      rsp_vld_q <= 1'b0;
    end else if (state_q == ST_TRAP) begin
      rsp_vld_q <= 1'b0;
    end else if (stall) begin
      rsp_vld_q <= rsp_vld_q;
    end else if (halt) begin
      rsp_vld_q <= 1'b0;
    end else begin
      rsp_vld_q <= 1'b1;
      pc_rsp_q  <= pc_req_q;
      pc_req_q  <= pc_req_q + 32'd4;
    end
  end

`ifdef IFU_MISALIGN_EXC_EN
  logic       mis_pulse_q;
  InstAddrBus mis_addr_q;

  // One-cycle misalign pulse and sticky capture of the offending target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_pulse_q <= 1'b0;
      mis_addr_q  <= '0;
    end else begin
      mis_pulse_q <= jump_bad;
      if (jump_bad) begin
        mis_addr_q <= jump_addr;
      end
    end
  end

  assign fetch_misalign = mis_pulse_q;
  assign misalign_addr  = mis_addr_q;
`else
  assign fetch_misalign = 1'b0;
  assign misalign_addr  = '0;
`endif

  // The BRAM holds its output while not enabled, so the word stays stable
  assign if_valid = rsp_vld_q & ~jump_en & (state_q == ST_RUN);
  assign if_inst  = iram_rdata;
  assign if_pc    = pc_rsp_q;

endmodule
`default_nettype wire

// File: doc/ifu.md
# ifu

Instruction fetch unit sitting directly upstream of the dual-port instruction BRAM (`isp`) and downstream-facing to decode. Owns the fetch PC, drives the BRAM A-port enable/address, accounts for its one-cycle registered read latency, and presents instruction/PC pairs to decode through a valid/ready handshake. Redirects (jumps, branches, traps) from execute flush the wrong-path instruction and restart fetch with no extra bubble beyond the killed slot.

## Interface
- `RESET_PC`, 32'h0000_0000, byte address fetched first after reset.
- `RAM_DEPTH`, 65536, BRAM depth in 32-bit words; `AW = clogb2(RAM_DEPTH-1)` address bits.
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `jump_en`  in  1  redirect request from execute.
- `jump_addr`  in  32  redirect byte address.
- `halt`  in  1  stop issuing new fetches (debug/sleep).
- `iram_en`  out  1  BRAM port-A enable.
- `iram_addr`  out  AW  BRAM word address (`pc[AW+1:2]`).
- `iram_rdata`  in  `InstBus`  BRAM port-A data, valid the cycle after `iram_en`.
- `if_valid`  out  1  instruction on `if_inst`/`if_pc` is valid.
- `id_ready`  in  1  decode accepts this cycle.
- `if_inst`  out  `InstBus`  fetched instruction.
- `if_pc`  out  32  byte address of `if_inst`.
- `fetch_misalign`  out  1  misaligned redirect pulse (macro-dependent).
- `misalign_addr`  out  32  offending target address.

## Operation
- Registers: `pc_req` (next address to request), `pc_rsp` (address of in-flight/presented word), `rsp_vld`, state.
- States: RUN, TRAP. Reset -> RUN. RUN -> TRAP on misaligned `jump_en` (macro on). TRAP -> RUN on aligned `jump_en`. `halt` does not change state.
- Stall = `rsp_vld & ~id_ready & ~jump_en`. During stall `iram_en=0`; BRAM holds its output, so `if_inst` stays stable; `pc_req`, `pc_rsp` hold.
- RUN, no jump, no stall, `halt=0`: `iram_en=1`, `iram_addr=pc_req` word; next cycle `rsp_vld=1`, `pc_rsp<=pc_req`, `pc_req<=pc_req+4`.
- `halt=1` and no jump: `iram_en=0`; a presented word stays until accepted, then `rsp_vld<=0`.
- `jump_en` (aligned, any state, overrides stall and halt): `if_valid` forced 0 this cycle (wrong-path kill); `iram_en=1`, `iram_addr=jump_addr` word; next cycle `rsp_vld=1`, `pc_rsp=jump_addr`, `pc_req=jump_addr+4`.
- TRAP: `iram_en=0`, `rsp_vld=0`, only `jump_en` is honoured.
- `if_valid = rsp_vld & ~jump_en & (state==RUN)`; `if_inst = iram_rdata`; `if_pc = pc_rsp`.
- Arithmetic: `pc_req+4` wraps modulo 2^32; BRAM address uses only bits `[AW+1:2]` (wraps modulo RAM_DEPTH); bits `[1:0]` never drive the BRAM.

## Timing
- Reset values: `pc_req=RESET_PC`, `pc_rsp=RESET_PC`, `rsp_vld=0`, state RUN, `fetch_misalign=0`, `misalign_addr=0`; combinational `iram_en=1` after reset release (first fetch on first cycle).
- Latency: request cycle N -> `if_valid` cycle N+1. Sustained throughput 1 instr/cycle while `id_ready=1`.
- Redirect penalty: exactly 1 cycle (killed slot in cycle of `jump_en`).
- Simultaneous `jump_en` and stall: jump wins; presented word dropped.
- Reset asserted mid-stall/mid-jump: all registers to reset values immediately; BRAM output content ignored since `rsp_vld=0`.

## Configuration
- `IFU_MISALIGN_EXC_EN` defined: `jump_en` with `jump_addr[1:0]!=0` issues no fetch, pulses `fetch_misalign` one cycle later for 1 cycle, captures `misalign_addr=jump_addr`, enters TRAP.
- Not defined: `jump_addr[1:0]` ignored (treated as 00), TRAP unreachable, `fetch_misalign` tied 0, `misalign_addr` tied 0.

## Structure
- `InstBus`, `InstAddrBus`, `RESET_PC` default and the state encodings belong in `defines.v`.
- `clogb2` address-width function shared with `isp`; no sub-module needed—single flat module.

## Test plan
- Reset release, `RESET_PC=0`, `id_ready=1` -> `iram_addr` 0,1,2,3; `if_pc` 0x0,0x4,0x8 from cycle 1, `if_valid` continuous.
- `id_ready=0` for 3 cycles while `if_pc=0x8` -> `iram_en=0`, `if_inst`/`if_pc` stable 3 cycles, then 0xC next after release.
- `jump_en`, `jump_addr=0x100` while stalled -> `if_valid=0` that cycle, next cycle `if_pc=0x100`, then 0x104.
- Macro on, `jump_addr=0x102` -> `fetch_misalign` 1-cycle pulse, `misalign_addr=0x102`, `if_valid=0` until `jump_en` to 0x200 -> `if_pc=0x200`.
- `halt=1` with `if_pc=0x10` unaccepted -> word held until `id_ready`, then `if_valid=0`, `iram_en=0`; `halt=0` -> resumes at 0x14.
- `pc_req=0xFFFF_FFFC`, `RAM_DEPTH=1024` -> `iram_addr=0x3FF`, next `pc_req=0x0`, `iram_addr=0`.
